// File: rtl/mem_arbiter.sv
// Two-master to one-slave memory arbiter: instruction fetch and data access share
// a single split-transaction bus with exactly one transaction outstanding.
module mem_arbiter #(
  parameter int DATA_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  // Handshake: bus_req with its payload is held until the cycle bus_addr_ok=1
  // (address accepted); the transaction then waits for bus_data_ok=1 (data
  // returned or write done). Owner-side *_ok outputs mirror those pulses.
  typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_t;

  state_t state;
  logic   last_data;
  logic   pick_data;

  // Data wins a tie when it has fixed priority or when inst was granted last.
  assign pick_data = data_req & (~inst_req | (DATA_PRIORITY != 0) | ~last_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last_data <= 1'b0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_wstrb <= 4'd0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_req | data_req) begin
            bus_req   <= 1'b1;
            last_data <= pick_data;
            if (pick_data) begin
              state     <= D_ADDR;
              bus_wr    <= data_wr;
              bus_size  <= data_size;
              bus_wstrb <= data_wstrb;
              bus_addr  <= data_addr;
              bus_wdata <= data_wdata;
            end else begin
              state     <= I_ADDR;
              bus_wr    <= 1'b0;
              bus_size  <= 2'd2;
              bus_wstrb <= 4'd0;
              bus_addr  <= inst_addr;
              bus_wdata <= 32'd0;
            end
          end
        end
        I_ADDR: begin
          if (bus_addr_ok) begin
            state   <= I_DATA;
            bus_req <= 1'b0;
          end
        end
        D_ADDR: begin
          if (bus_addr_ok) begin
            state   <= D_DATA;
            bus_req <= 1'b0;
          end
        end
        I_DATA, D_DATA: begin
          if (bus_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus acknowledges only reach the side that owns the matching phase.
  assign inst_addr_ok = (state == I_ADDR) & bus_addr_ok;
  assign inst_data_ok = (state == I_DATA) & bus_data_ok;
  assign data_addr_ok = (state == D_ADDR) & bus_addr_ok;
  assign data_data_ok = (state == D_DATA) & bus_data_ok;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (data-priority and round-robin) share the
// same stimulus; directed vectors, corner sequences and a randomized model check.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir, dr, dw, aok, dok;
  logic [1:0]  ds;
  logic [3:0]  dws;
  logic [31:0] ia, da, dwd, brd;

  // index 1: DATA_PRIORITY=1, index 0: DATA_PRIORITY=0
  logic        iao[2], ido[2], dao[2], ddo[2];
  logic [31:0] irdata[2], drdata[2];
  logic        breq[2], bwr[2];
  logic [1:0]  bsize[2];
  logic [3:0]  bwstrb[2];
  logic [31:0] baddr[2], bwdata[2];

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_PRIORITY(1)) dut_p1 (
    .clk(clk), .rst(rst),
    .inst_req(ir), .inst_addr(ia), .inst_addr_ok(iao[1]), .inst_data_ok(ido[1]),
    .inst_rdata(irdata[1]),
    .data_req(dr), .data_wr(dw), .data_size(ds), .data_wstrb(dws), .data_addr(da),
    .data_wdata(dwd), .data_addr_ok(dao[1]), .data_data_ok(ddo[1]), .data_rdata(drdata[1]),
    .bus_req(breq[1]), .bus_wr(bwr[1]), .bus_size(bsize[1]), .bus_wstrb(bwstrb[1]),
    .bus_addr(baddr[1]), .bus_wdata(bwdata[1]),
    .bus_addr_ok(aok), .bus_data_ok(dok), .bus_rdata(brd)
  );

  mem_arbiter #(.DATA_PRIORITY(0)) dut_p0 (
    .clk(clk), .rst(rst),
    .inst_req(ir), .inst_addr(ia), .inst_addr_ok(iao[0]), .inst_data_ok(ido[0]),
    .inst_rdata(irdata[0]),
    .data_req(dr), .data_wr(dw), .data_size(ds), .data_wstrb(dws), .data_addr(da),
    .data_wdata(dwd), .data_addr_ok(dao[0]), .data_data_ok(ddo[0]), .data_rdata(drdata[0]),
    .bus_req(breq[0]), .bus_wr(bwr[0]), .bus_size(bsize[0]), .bus_wstrb(bwstrb[0]),
    .bus_addr(baddr[0]), .bus_wdata(bwdata[0]),
    .bus_addr_ok(aok), .bus_data_ok(dok), .bus_rdata(brd)
  );

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ir = 0; dr = 0; dw = 0; aok = 0; dok = 0; ds = 2'd2; dws = 4'hF;
    ia = 32'hBFC0_0000; da = 32'h8000_0010; dwd = 32'hDEAD_BEEF; brd = 32'h2408_0001;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // Transaction-level reference model, one slot per instance.
  logic        m_have[2], m_acc[2], m_side[2], m_last[2];
  logic [70:0] m_pay[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_have[k] = 0; m_acc[k] = 0; m_side[k] = 0; m_last[k] = 0; m_pay[k] = '0;
    end
  endtask

  task automatic model_check(input int k);
    logic [70:0] act;
    act = {bwr[k], bsize[k], bwstrb[k], baddr[k], bwdata[k]};
    check("rnd_bus_req", breq[k], m_have[k] & ~m_acc[k]);
    check("rnd_payload", act, m_pay[k]);
    check("rnd_inst_addr_ok", iao[k], m_have[k] & ~m_acc[k] & ~m_side[k] & aok);
    check("rnd_data_addr_ok", dao[k], m_have[k] & ~m_acc[k] & m_side[k] & aok);
    check("rnd_inst_data_ok", ido[k], m_have[k] & m_acc[k] & ~m_side[k] & dok);
    check("rnd_data_data_ok", ddo[k], m_have[k] & m_acc[k] & m_side[k] & dok);
    check("rnd_rdata", {irdata[k], drdata[k]}, {brd, brd});
  endtask

  task automatic model_step(input int k);
    logic win_data;
    if (m_have[k]) begin
      if (!m_acc[k]) begin
        if (aok) m_acc[k] = 1;
      end else if (dok) begin
        m_have[k] = 0;
      end
    end else if (ir || dr) begin
      win_data = dr && (!ir || k == 1 || !m_last[k]);
      m_side[k] = win_data;
      m_last[k] = win_data;
      m_have[k] = 1;
      m_acc[k]  = 0;
      m_pay[k]  = win_data ? {dw, ds, dws, da, dwd} : {1'b0, 2'd2, 4'd0, ia, 32'd0};
    end
  endtask

  typedef struct {
    logic [3:0]  stim;     // {inst_req, data_req, bus_addr_ok, bus_data_ok}
    logic [5:0]  exp;      // {bus_req, bus_wr, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}
    logic [31:0] e_baddr;
  } vec_t;

  vec_t tbl[12];
  logic [0:0] exp_q[$];
  logic [70:0] held;
  int grants;

  initial begin
    tbl[0]  = '{4'b1011, 6'b000000, 32'h0000_0000};
    tbl[1]  = '{4'b0010, 6'b101000, 32'hBFC0_0000};
    tbl[2]  = '{4'b0001, 6'b000100, 32'hBFC0_0000};
    tbl[3]  = '{4'b1110, 6'b000000, 32'hBFC0_0000};
    tbl[4]  = '{4'b1100, 6'b110000, 32'h8000_0010};
    tbl[5]  = '{4'b1110, 6'b110010, 32'h8000_0010};
    tbl[6]  = '{4'b1100, 6'b010000, 32'h8000_0010};
    tbl[7]  = '{4'b1001, 6'b010001, 32'h8000_0010};
    tbl[8]  = '{4'b1010, 6'b010000, 32'h8000_0010};
    tbl[9]  = '{4'b0010, 6'b101000, 32'hBFC0_0000};
    tbl[10] = '{4'b0001, 6'b000100, 32'hBFC0_0000};
    tbl[11] = '{4'b0000, 6'b000000, 32'hBFC0_0000};

    // Reset state with acks and requests asserted: everything reads 0.
    clear_inputs();
    rst = 1; ir = 1; dr = 1; aok = 1; dok = 1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("reset_bus", {breq[k], bwr[k], bsize[k], bwstrb[k], baddr[k], bwdata[k]}, 96'd0);
      check("reset_oks", {iao[k], ido[k], dao[k], ddo[k]}, 96'd0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clear_inputs();

    // Directed vectors on the data-priority instance.
    dw = 1;
    for (int i = 0; i < 12; i++) begin
      {ir, dr, aok, dok} = tbl[i].stim;
      @(negedge clk);
      check($sformatf("vec%0d_flags", i),
            {breq[1], bwr[1], iao[1], ido[1], dao[1], ddo[1]}, tbl[i].exp);
      check($sformatf("vec%0d_addr", i), baddr[1], tbl[i].e_baddr);
      check($sformatf("vec%0d_rdata", i), irdata[1], 32'h2408_0001);
      if (breq[1]) begin
        check($sformatf("vec%0d_size", i), bsize[1], 2'd2);
        check($sformatf("vec%0d_wstrb", i), bwstrb[1], tbl[i].exp[4] ? 4'hF : 4'h0);
      end
      next_cycle();
    end

    // Round-robin instance: continuous ties alternate, data first.
    do_reset();
    ir = 1; dr = 1; dw = 1; aok = 1; dok = 1;
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
    grants = 0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      @(negedge clk);
      if (breq[0]) begin
        check($sformatf("rr_grant%0d", grants), bwr[0], exp_q.pop_front());
        grants++;
      end
      next_cycle();
    end
    check("rr_grant_count", grants, 4);

    // Bus stall: address phase held for 5 cycles.
    do_reset();
    dr = 1; dw = 0; ds = 2'd1; dws = 4'h3; da = 32'h0000_1236; dwd = 32'h1234_5678;
    held = {1'b0, 2'd1, 4'h3, 32'h0000_1236, 32'h1234_5678};
    next_cycle();
    dr = 0; da = 32'hFFFF_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_req", c), breq[1], 1'b1);
      check($sformatf("stall%0d_payload", c),
            {bwr[1], bsize[1], bwstrb[1], baddr[1], bwdata[1]}, held);
      check($sformatf("stall%0d_oks", c), {iao[1], ido[1], dao[1], ddo[1]}, 4'b0000);
      next_cycle();
    end
    aok = 1;
    @(negedge clk);
    check("stall_addr_ok", dao[1], 1'b1);
    next_cycle();
    aok = 0; dok = 1; brd = 32'hCAFE_F00D;
    @(negedge clk);
    check("stall_data_ok", {ddo[1], drdata[1]}, {1'b1, 32'hCAFE_F00D});
    next_cycle();

    // Async reset in the data phase, then a fresh fetch.
    do_reset();
    dr = 1; dw = 1;
    next_cycle();
    dr = 0; aok = 1;
    @(negedge clk);
    check("ar_addr_ok", dao[1], 1'b1);
    next_cycle();
    aok = 0; dok = 1;
    #2 rst = 1;
    #1;
    check("ar_bus_req", breq[1], 1'b0);
    check("ar_no_data_ok", ddo[1], 1'b0);
    check("ar_bus_addr", baddr[1], 32'd0);
    next_cycle();
    rst = 0; dok = 0;
    ir = 1; ia = 32'hBFC0_0100; aok = 1; dok = 1;
    @(negedge clk);
    check("ar_idle_stray", {iao[1], ido[1], dao[1], ddo[1]}, 4'b0000);
    next_cycle();
    ir = 0;
    @(negedge clk);
    check("ar_fetch_addr", {breq[1], iao[1], baddr[1]}, {1'b1, 1'b1, 32'hBFC0_0100});
    next_cycle();
    @(negedge clk);
    check("ar_fetch_data", {breq[1], ido[1], irdata[1]}, {1'b0, 1'b1, brd});
    next_cycle();

    // Randomized traffic against the transaction model on both instances.
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      ir  = ($urandom_range(0, 3) != 0);
      dr  = ($urandom_range(0, 3) != 0);
      dw  = $urandom_range(0, 1);
      ds  = $urandom_range(0, 2);
      dws = $urandom_range(0, 15);
      ia  = $urandom; da = $urandom; dwd = $urandom; brd = $urandom;
      aok = $urandom_range(0, 1);
      dok = $urandom_range(0, 1);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        model_check(k);
        model_step(k);
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
